// File: rtl/transport_receiver.sv
// Receive-side transport: parses SYNC/TYPE/PHONE/LEN/words/CHK frames into a commit/rollback word buffer.
// Optional build macro RX_CHECKSUM_EN enables CHK comparison; without it CHK is consumed and ignored.
module transport_receiver #(
   parameter logic [7:0] SYNC   = 8'h7E,
   parameter int         ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        byteIn,
   input  logic              byteValid,
   input  logic              rdEn,
   output logic [15:0]       dataOut,
   output logic              dataValid,
   output logic [1:0]        cmd,
   output logic [7:0]        phoneNum,
   output logic              frameValid,
   output logic              frameError,
   output logic [ADDR_W-1:0] bufCount,
   output logic              bufEmpty,
   output logic              busy
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] CAP = '1;

   typedef enum logic [2:0] {
      S_HUNT, S_TYPE, S_PHONE, S_LEN, S_DHI, S_DLO, S_CHK
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] rp, wpCommit, wpTent, tentOcc;
   logic              bad, full, memWr, chkOk;
   logic [7:0]        cnt, hiByte, phoneReg;
   logic [1:0]        typeReg;
   logic [15:0]       mem [0:DEPTH-1];

   assign tentOcc  = wpTent - rp;
   assign full     = (tentOcc == CAP);
   assign memWr    = byteValid && (state == S_DLO) && !bad && !full;
   assign bufCount = wpCommit - rp;
   assign bufEmpty = (bufCount == '0);
   assign busy     = (state != S_HUNT);

`ifdef RX_CHECKSUM_EN
   logic [7:0] chk;

   always_ff @(posedge clk) begin
      if (byteValid) begin
         if (state == S_TYPE)
            chk <= byteIn;
         else if (state inside {S_PHONE, S_LEN, S_DHI, S_DLO})
            chk <= chk ^ byteIn;
      end
   end

   assign chkOk = (chk == byteIn);
`else
   assign chkOk = 1'b1;
`endif

   // Control: FSM, pointers, status pulses and the read port
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_HUNT;
         rp         <= '0;
         wpCommit   <= '0;
         wpTent     <= '0;
         bad        <= 1'b0;
         cmd        <= 2'b00;
         phoneNum   <= 8'h00;
         frameValid <= 1'b0;
         frameError <= 1'b0;
         dataValid  <= 1'b0;
         dataOut    <= 16'h0000;
      end else begin
         frameValid <= 1'b0;
         frameError <= 1'b0;
         dataValid  <= rdEn && !bufEmpty;
         if (rdEn && !bufEmpty) begin
            dataOut <= mem[rp];
            rp      <= rp + 1'b1;
         end
         if (byteValid) begin
            case (state)
               S_HUNT:  if (byteIn == SYNC) state <= S_TYPE;
               S_TYPE: begin
                  if (byteIn[1:0] == 2'b00 || byteIn[7:2] != 6'd0) begin
                     frameError <= 1'b1;
                     state      <= S_HUNT;
                  end else begin
                     bad   <= 1'b0;
                     state <= S_PHONE;
                  end
               end
               S_PHONE: state <= S_LEN;
               S_LEN:   state <= (byteIn == 8'd0) ? S_CHK : S_DHI;
               S_DHI:   state <= S_DLO;
               S_DLO: begin
                  // A word that would overfill the buffer poisons the frame; the rest is still consumed
                  if (full)
                     bad <= 1'b1;
                  else if (!bad)
                     wpTent <= wpTent + 1'b1;
                  state <= (cnt == 8'd1) ? S_CHK : S_DHI;
               end
               S_CHK: begin
                  if (!bad && chkOk) begin
                     wpCommit   <= wpTent;
                     cmd        <= typeReg;
                     phoneNum   <= phoneReg;
                     frameValid <= 1'b1;
                  end else begin
                     wpTent     <= wpCommit;
                     frameError <= 1'b1;
                  end
                  state <= S_HUNT;
               end
               default: state <= S_HUNT;
            endcase
         end
      end
   end

   // Data: frame fields, word assembly and buffer storage
   always_ff @(posedge clk) begin
      if (byteValid) begin
         case (state)
            S_TYPE:  typeReg  <= byteIn[1:0];
            S_PHONE: phoneReg <= byteIn;
            S_LEN:   cnt      <= byteIn;
            S_DHI:   hiByte   <= byteIn;
            S_DLO:   cnt      <= cnt - 8'd1;
            default: ;
         endcase
      end
      if (memWr)
         mem[wpTent] <= {hiByte, byteIn};
   end

endmodule

// File: tb/tb_transport_receiver.sv
// Self-checking bench for transport_receiver: vector table, directed corner cases, random frames vs a queue model.
module tb_transport_receiver;
   localparam int AW  = 3;
   localparam int CAP = (1 << AW) - 1;
`ifdef RX_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset, byteValid, rdEn;
   logic [7:0]    byteIn;
   logic [15:0]   dataOut;
   logic          dataValid, frameValid, frameError, bufEmpty, busy;
   logic [1:0]    cmd;
   logic [7:0]    phoneNum;
   logic [AW-1:0] bufCount;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   transport_receiver #(.SYNC(8'h7E), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .byteIn(byteIn), .byteValid(byteValid), .rdEn(rdEn),
      .dataOut(dataOut), .dataValid(dataValid), .cmd(cmd), .phoneNum(phoneNum),
      .frameValid(frameValid), .frameError(frameError), .bufCount(bufCount),
      .bufEmpty(bufEmpty), .busy(busy)
   );

   // Reference model: committed words in order, last accepted command/phone, last popped word
   logic [15:0] mq[$];
   logic [15:0] wq[$];
   logic [7:0]  fb[$];
   logic [1:0]  mcmd;
   logic [7:0]  mph;
   logic [15:0] lastOut;
   logic [15:0] exp_w;
   logic [7:0]  tb_b, rtyp, rph;
   int          rlen;
   bit          rcor, good;

   typedef struct {
      logic [95:0] bits;
      int          n;
      logic        fv;
      logic        fe;
      logic [1:0]  cmd;
      logic [7:0]  ph;
      int          cnt;
   } vec_t;
   vec_t tbl[6];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) @(negedge clk);
      byteIn    = b;
      byteValid = 1'b1;
      @(negedge clk);
      byteValid = 1'b0;
   endtask

   task automatic build(input logic [7:0] typ, input logic [7:0] ph, input int len, input bit corrupt);
      logic [7:0] c;
      fb.delete();
      fb.push_back(8'h7E);
      fb.push_back(typ);
      if (typ[1:0] == 2'b00 || typ[7:2] != 6'd0) return;
      fb.push_back(ph);
      fb.push_back(8'(len));
      c = typ ^ ph ^ 8'(len);
      for (int i = 0; i < len; i++) begin
         fb.push_back(wq[i][15:8]);
         fb.push_back(wq[i][7:0]);
         c = c ^ wq[i][15:8] ^ wq[i][7:0];
      end
      if (corrupt) c = c ^ 8'h5A;
      fb.push_back(c);
   endtask

   function automatic bit model_frame(input logic [7:0] typ, input logic [7:0] ph, input int len,
                                      input bit corrupt);
      bit ok;
      ok = (typ[1:0] != 2'b00) && (typ[7:2] == 6'd0) && (mq.size() + len <= CAP) && !(CK && corrupt);
      if (ok) begin
         for (int i = 0; i < len; i++) mq.push_back(wq[i]);
         mcmd = typ[1:0];
         mph  = ph;
      end
      return ok;
   endfunction

   task automatic check_frame(input string nm, input bit ok);
      check({nm, "_fv"}, frameValid, ok);
      check({nm, "_fe"}, frameError, !ok);
      check({nm, "_cmd"}, cmd, mcmd);
      check({nm, "_phone"}, phoneNum, mph);
      check({nm, "_cnt"}, bufCount, mq.size());
      check({nm, "_empty"}, bufEmpty, mq.size() == 0);
      check({nm, "_busy"}, busy, 0);
      @(negedge clk);
      check({nm, "_pulse"}, {frameValid, frameError}, 2'b00);
   endtask

   task automatic run_frame(input string nm, input logic [7:0] typ, input logic [7:0] ph, input int len,
                            input bit corrupt, input int maxgap);
      bit ok;
      build(typ, ph, len, corrupt);
      ok = model_frame(typ, ph, len, corrupt);
      for (int i = 0; i < fb.size(); i++) send_byte(fb[i], $urandom_range(0, maxgap));
      check_frame(nm, ok);
   endtask

   task automatic read_one(input string nm);
      bit has;
      has = (mq.size() != 0);
      if (has) lastOut = mq.pop_front();
      rdEn = 1'b1;
      @(negedge clk);
      rdEn = 1'b0;
      check({nm, "_dv"}, dataValid, has);
      check({nm, "_data"}, dataOut, lastOut);
      check({nm, "_cnt"}, bufCount, mq.size());
   endtask

   initial begin
      reset = 1'b1; byteValid = 1'b0; rdEn = 1'b0; byteIn = 8'h00;
      mcmd = 2'b00; mph = 8'h00; lastOut = 16'h0000;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_outputs", {dataValid, frameValid, frameError, busy, bufEmpty}, 5'b00001);
      check("rst_cmd_phone", {cmd, phoneNum}, 10'h000);
      check("rst_data_cnt", {dataOut, bufCount}, '0);

      tbl[0] = '{96'h7E_02_05_02_A3_F1_12_34_71, 9, 1'b1, 1'b0, 2'b10, 8'h05, 2};
      tbl[1] = '{96'h7E_01_2A_00_2B, 5, 1'b1, 1'b0, 2'b01, 8'h2A, 2};
      tbl[2] = '{96'h7E_02_05_02_A3_F1_12_34_00, 9, !CK, CK, CK ? 2'b01 : 2'b10, CK ? 8'h2A : 8'h05,
                 CK ? 2 : 4};
      tbl[3] = '{96'h7E_00, 2, 1'b0, 1'b1, tbl[2].cmd, tbl[2].ph, tbl[2].cnt};
      tbl[4] = '{96'h7E_05, 2, 1'b0, 1'b1, tbl[2].cmd, tbl[2].ph, tbl[2].cnt};
      tbl[5] = '{96'h7E_03_11_01_BE_EF_42, 7, 1'b1, 1'b0, 2'b11, 8'h11, CK ? 3 : 5};

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < tbl[r].n; i++) begin
            tb_b = tbl[r].bits[8*(tbl[r].n-1-i) +: 8];
            send_byte(tb_b, 0);
         end
         check($sformatf("tbl%0d_fv", r), frameValid, tbl[r].fv);
         check($sformatf("tbl%0d_fe", r), frameError, tbl[r].fe);
         check($sformatf("tbl%0d_cmd", r), cmd, tbl[r].cmd);
         check($sformatf("tbl%0d_phone", r), phoneNum, tbl[r].ph);
         check($sformatf("tbl%0d_cnt", r), bufCount, tbl[r].cnt);
         check($sformatf("tbl%0d_busy", r), busy, 0);
         @(negedge clk);
         check($sformatf("tbl%0d_pulse", r), {frameValid, frameError}, 2'b00);
      end

`ifdef RX_CHECKSUM_EN
      mq = '{16'hA3F1, 16'h1234, 16'hBEEF};
`else
      mq = '{16'hA3F1, 16'h1234, 16'hA3F1, 16'h1234, 16'hBEEF};
`endif
      mcmd = 2'b11; mph = 8'h11;
      while (mq.size() != 0) read_one("drain_tbl");
      read_one("read_empty");

      // Overflow: 5 committed, then a 3-word frame must be rolled back
      wq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
      run_frame("ovf_fill", 8'h02, 8'h09, 5, 1'b0, 0);
      wq = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
      run_frame("ovf_drop", 8'h01, 8'h08, 3, 1'b0, 0);

      // Commit landing in the same cycle as a pop
      wq = '{16'h6666};
      build(8'h01, 8'h44, 1, 1'b0);
      good = model_frame(8'h01, 8'h44, 1, 1'b0);
      for (int i = 0; i < fb.size() - 1; i++) send_byte(fb[i], 0);
      exp_w = mq.pop_front();
      lastOut = exp_w;
      byteIn = fb[fb.size()-1]; byteValid = 1'b1; rdEn = 1'b1;
      @(negedge clk);
      byteValid = 1'b0; rdEn = 1'b0;
      check("cp_fv", frameValid, good);
      check("cp_dv", dataValid, 1);
      check("cp_data", dataOut, exp_w);
      check("cp_cnt", bufCount, mq.size());
      while (mq.size() != 0) read_one("drain_ovf");

      // Reset while in the middle of a frame's data words
      wq = '{16'h0F0F, 16'hF0F0};
      run_frame("pre_rst", 8'h02, 8'h33, 2, 1'b0, 0);
      send_byte(8'h7E, 0);
      check("busy_after_sync", busy, 1);
      send_byte(8'h02, 0); send_byte(8'h05, 0); send_byte(8'h03, 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      mq.delete(); mcmd = 2'b00; mph = 8'h00; lastOut = 16'h0000;
      check("midrst_fe", frameError, 0);
      check("midrst_state", {busy, bufEmpty, bufCount}, {2'b01, 3'd0});
      check("midrst_cmd_phone", {cmd, phoneNum, dataOut}, '0);
      wq = '{16'h7E7E, 16'h1357};
      run_frame("post_rst", 8'h03, 8'h66, 2, 1'b0, 1);
      while (mq.size() != 0) read_one("drain_rst");

      // Random traffic against the model
      for (int f = 0; f < 80; f++) begin
         repeat ($urandom_range(0, 2)) begin
            tb_b = 8'($urandom);
            if (tb_b == 8'h7E) tb_b = 8'h00;
            send_byte(tb_b, $urandom_range(0, 1));
         end
         check("rnd_hunt_busy", busy, 0);
         case ($urandom_range(0, 9))
            0:       rtyp = 8'h00;
            1:       rtyp = {6'($urandom_range(1, 63)), 2'($urandom)};
            default: rtyp = {6'd0, 2'($urandom_range(1, 3))};
         endcase
         rph  = 8'($urandom);
         rlen = $urandom_range(0, 4);
         rcor = ($urandom_range(0, 5) == 0);
         wq.delete();
         for (int i = 0; i < rlen; i++) wq.push_back(16'($urandom));
         run_frame($sformatf("rnd%0d", f), rtyp, rph, rlen, rcor, 2);
         repeat ($urandom_range(0, 3)) read_one($sformatf("rnd%0d_rd", f));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
